// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : fpu_pkg
//  Purpose   : Shared constants, class flag indices and pack-class encoding
//              for the FPU writeback packer.
//  Revision  : 1.0  initial release
// ============================================================================
package fpu_pkg;

  // Class flag bit positions within fl[3:0]
  localparam int FL_ZERO = 3;
  localparam int FL_INF  = 2;
  localparam int FL_SNAN = 1;
  localparam int FL_NAN  = 0;

  // Format field widths
  localparam int EXP_W_D  = 11;
  localparam int FRAC_W_D = 52;
  localparam int EXP_W_S  = 8;
  localparam int FRAC_W_S = 23;

  // All-ones exponent fields
  localparam logic [EXP_W_D-1:0] EXP_ONES_D = 11'h7FF;
  localparam logic [EXP_W_S-1:0] EXP_ONES_S = 8'hFF;

  // Resolved class of a result after flag priority has been applied
  typedef enum logic [1:0] {
    PK_FIN  = 2'd0,
    PK_ZERO = 2'd1,
    PK_INF  = 2'd2,
    PK_NAN  = 2'd3
  } pk_class_e;

  // Priority: any NaN flag > INF > ZERO > finite
  function automatic pk_class_e pk_classify(input logic [3:0] fl);
    pk_class_e cls;
    if (fl[FL_NAN] || fl[FL_SNAN]) begin
      cls = PK_NAN;
    end else if (fl[FL_INF]) begin
      cls = PK_INF;
    end else if (fl[FL_ZERO]) begin
      cls = PK_ZERO;
    end else begin
      cls = PK_FIN;
    end
    return cls;
  endfunction

endpackage
`default_nettype wire

// File: rtl/packer_assemble.sv
`default_nettype none
// ============================================================================
//  Module    : packer_assemble
//  Purpose   : Combinational assembly of sign/exponent/fraction into a 64-bit
//              IEEE-754 word. Double fills the whole word; single occupies
//              the upper half with the lower half zero.
//  Revision  : 1.0  initial release
// ============================================================================
module packer_assemble
  import fpu_pkg::*;
(
  input  logic                db,
  input  logic                sign,
  input  logic [EXP_W_D-1:0]  exp_fld,   // single uses exp_fld[7:0]
  input  logic [FRAC_W_D-1:0] frac_fld,  // single uses frac_fld[22:0]
  output logic [63:0]         word
);

  // Select the field layout for the beat's format
  always_comb begin
    word = 64'h0;
    if (db) begin
      word = {sign, exp_fld, frac_fld};
    end else begin
      word = {sign, exp_fld[EXP_W_S-1:0], frac_fld[FRAC_W_S-1:0], 32'h0};
    end
  end

endmodule
`default_nettype wire

// File: rtl/packer_pipe.sv
`default_nettype none
// ============================================================================
//  Module    : packer_pipe
//  Purpose   : Writeback packer. Stage 1 resolves the result class and forms
//              sign/exponent/fraction; stage 2 assembles and holds the packed
//              IEEE-754 word. Valid/ready pipeline with full throughput,
//              sticky invalid flag and a count of delivered results.
//  Revision  : 1.0  initial release
// ============================================================================
module packer_pipe
  import fpu_pkg::*;
#(
  parameter logic QNAN_SIGN = 1'b0,
  parameter int   CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             db,
  input  logic             s,
  input  logic [10:0]      e,
  input  logic [52:0]      f,
  input  logic [3:0]       fl,
  input  logic [52:0]      nan,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      fp,
  output logic             inv,
  output logic             inv_sticky,
  input  logic             inv_clr,
  output logic [CNT_W-1:0] pack_cnt
);

  // Stage 1 state
  logic                s1_valid_q, s1_valid_d;
  logic                s1_db_q,    s1_db_d;
  logic                s1_sign_q,  s1_sign_d;
  logic [EXP_W_D-1:0]  s1_exp_q,   s1_exp_d;
  logic [FRAC_W_D-1:0] s1_frac_q,  s1_frac_d;
  logic                s1_inv_q,   s1_inv_d;

  // Stage 2 state (drives the outputs directly)
  logic                s2_valid_q, s2_valid_d;
  logic [63:0]         fp_q,       fp_d;
  logic                inv_q,      inv_d;

  // Status state
  logic                sticky_q,   sticky_d;
  logic [CNT_W-1:0]    cnt_q,      cnt_d;

  // Handshake and datapath wires
  logic                adv1, adv2, out_xfer;
  pk_class_e           cls;
  logic                c_sign, c_inv;
  logic [EXP_W_D-1:0]  c_exp;
  logic [FRAC_W_D-1:0] c_frac;
  logic [63:0]         asm_word;

  // Advance conditions; in_ready depends on out_ready combinationally only
  always_comb begin
    adv2     = !s2_valid_q || out_ready;
    adv1     = !s1_valid_q || adv2;
    out_xfer = s2_valid_q && out_ready;
  end

  // Classify the incoming beat and build its fields in format-native layout
  always_comb begin
    cls    = pk_classify(fl);
    c_sign = s;
    c_exp  = '0;
    c_frac = '0;
    c_inv  = 1'b0;
    unique case (cls)
      PK_NAN: begin
        // Quiet the NaN: fraction MSB forced, payload kept below it
        c_sign = QNAN_SIGN;
        c_inv  = nan[52] || fl[FL_SNAN];
        if (db) begin
          c_exp  = EXP_ONES_D;
          c_frac = {1'b1, nan[50:0]};
        end else begin
          c_exp  = {3'b000, EXP_ONES_S};
          c_frac = {29'h0, 1'b1, nan[50:29]};
        end
      end
      PK_INF: begin
        c_exp = db ? EXP_ONES_D : {3'b000, EXP_ONES_S};
      end
      PK_ZERO: begin
        c_exp = '0;
      end
      default: begin
        // Finite: no hidden bit means denormal; all-ones exponent passes as is
        if (!f[52]) begin
          c_exp = '0;
        end else if (db) begin
          c_exp = e;
        end else begin
          c_exp = {3'b000, e[7:0]};
        end
        c_frac = db ? f[51:0] : {29'h0, f[51:29]};
      end
    endcase
  end

  // Stage 1 next state: load on acceptance, hold when stalled
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_db_d    = s1_db_q;
    s1_sign_d  = s1_sign_q;
    s1_exp_d   = s1_exp_q;
    s1_frac_d  = s1_frac_q;
    s1_inv_d   = s1_inv_q;
    if (adv1) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_db_d   = db;
        s1_sign_d = c_sign;
        s1_exp_d  = c_exp;
        s1_frac_d = c_frac;
        s1_inv_d  = c_inv;
      end
    end
  end

  packer_assemble u_assemble (
    .db       (s1_db_q),
    .sign     (s1_sign_q),
    .exp_fld  (s1_exp_q),
    .frac_fld (s1_frac_q),
    .word     (asm_word)
  );

  // Stage 2 next state: output word and inv held while downstream stalls
  always_comb begin
    s2_valid_d = s2_valid_q;
    fp_d       = fp_q;
    inv_d      = inv_q;
    if (adv2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        fp_d  = asm_word;
        inv_d = s1_inv_q;
      end
    end
  end

  // Sticky invalid and delivered-result counter; a set beats a clear
  always_comb begin
    sticky_d = sticky_q;
    if (out_xfer && inv_q) begin
      sticky_d = 1'b1;
    end else if (inv_clr) begin
      sticky_d = 1'b0;
    end
    cnt_d = cnt_q + CNT_W'(out_xfer);
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_db_q    <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_frac_q  <= '0;
      s1_inv_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      fp_q       <= 64'h0;
      inv_q      <= 1'b0;
      sticky_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_db_q    <= s1_db_d;
      s1_sign_q  <= s1_sign_d;
      s1_exp_q   <= s1_exp_d;
      s1_frac_q  <= s1_frac_d;
      s1_inv_q   <= s1_inv_d;
      s2_valid_q <= s2_valid_d;
      fp_q       <= fp_d;
      inv_q      <= inv_d;
      sticky_q   <= sticky_d;
      cnt_q      <= cnt_d;
    end
  end

  // Output mapping
  always_comb begin
    in_ready   = adv1;
    out_valid  = s2_valid_q;
    fp         = fp_q;
    inv        = inv_q;
    inv_sticky = sticky_q;
    pack_cnt   = cnt_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_packer_pipe.sv
`default_nettype none
// ============================================================================
//  Module    : tb_packer_pipe
//  Purpose   : Directed self-checking bench for packer_pipe.
//  Revision  : 1.0  initial release
// ============================================================================
module tb_packer_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        db;
  logic        s;
  logic [10:0] e;
  logic [52:0] f;
  logic [3:0]  fl;
  logic [52:0] nan;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] fp;
  logic        inv;
  logic        inv_sticky;
  logic        inv_clr;
  logic [15:0] pack_cnt;

  int n_eval;
  int n_fail;
  int exp_cnt;
  logic exp_sticky;

  packer_pipe #(.QNAN_SIGN(1'b0), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .db         (db),
    .s          (s),
    .e          (e),
    .f          (f),
    .fl         (fl),
    .nan        (nan),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fp         (fp),
    .inv        (inv),
    .inv_sticky (inv_sticky),
    .inv_clr    (inv_clr),
    .pack_cnt   (pack_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_eval++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One beat through an empty pipe with out_ready high; called right after a negedge
  task automatic run_vec(input string tag, input logic vdb, input logic vs,
                         input logic [10:0] ve, input logic [52:0] vf,
                         input logic [3:0] vfl, input logic [52:0] vnan,
                         input logic [63:0] exp_fp, input logic exp_inv,
                         input logic clr_at_out);
    in_valid = 1'b1; db = vdb; s = vs; e = ve; f = vf; fl = vfl; nan = vnan;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_fp"}, fp, exp_fp);
    chk({tag, "_inv"}, 64'(inv), 64'(exp_inv));
    inv_clr = clr_at_out;
    @(negedge clk);
    inv_clr = 1'b0;
    exp_cnt++;
    if (exp_inv) exp_sticky = 1'b1;
    else if (clr_at_out) exp_sticky = 1'b0;
    chk({tag, "_cnt"}, 64'(pack_cnt), 64'(exp_cnt));
    chk({tag, "_sticky"}, 64'(inv_sticky), 64'(exp_sticky));
    chk({tag, "_drain"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int sent;
    int got;
    int cyc;
    logic prev_stall;
    logic [63:0] prev_fp;

    n_eval = 0; n_fail = 0; exp_cnt = 0; exp_sticky = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; inv_clr = 1'b0;
    db = 1'b0; s = 1'b0; e = '0; f = '0; fl = '0; nan = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_fp", fp, 64'h0);
    chk("rst_inv", 64'(inv), 64'd0);
    chk("rst_sticky", 64'(inv_sticky), 64'd0);
    chk("rst_cnt", 64'(pack_cnt), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors
    run_vec("d_one",   1'b1, 1'b0, 11'h3FF, 53'h1 << 52, 4'b0000, 53'h0,
            64'h3FF0000000000000, 1'b0, 1'b0);
    run_vec("s_m_one", 1'b0, 1'b1, 11'h07F, 53'h1 << 52, 4'b0000, 53'h0,
            64'hBF80000000000000, 1'b0, 1'b0);
    run_vec("d_ninf",  1'b1, 1'b1, 11'h123, 53'h1F, 4'b0100, 53'h0,
            64'hFFF0000000000000, 1'b0, 1'b0);
    run_vec("d_nzero", 1'b1, 1'b1, 11'h3FF, 53'h1_2345_6789_ABCD, 4'b1000, 53'h0,
            64'h8000000000000000, 1'b0, 1'b0);
    run_vec("zero_inf", 1'b1, 1'b0, 11'h001, 53'h1 << 52, 4'b1100, 53'h0,
            64'h7FF0000000000000, 1'b0, 1'b0);
    run_vec("d_denorm", 1'b1, 1'b0, 11'h005, 53'h1, 4'b0000, 53'h0,
            64'h0000000000000001, 1'b0, 1'b0);
    run_vec("d_expones", 1'b1, 1'b0, 11'h7FF, (53'h1 << 52) | 53'h5, 4'b0000, 53'h0,
            64'h7FF0000000000005, 1'b0, 1'b0);
    run_vec("s_trunc", 1'b0, 1'b0, 11'h480, (53'h1 << 52) | (53'h1 << 29) | 53'h1FFF_FFFF,
            4'b0000, 53'h0, 64'h4000000100000000, 1'b0, 1'b0);
    run_vec("s_qnan",  1'b0, 1'b1, 11'h0, 53'h0, 4'b0001, 53'h0_0000_2000_0000,
            64'h7FC0000100000000, 1'b0, 1'b0);
    run_vec("nan_inf", 1'b1, 1'b1, 11'h0, 53'h0, 4'b0101, 53'h123,
            64'h7FF8000000000123, 1'b0, 1'b0);
    run_vec("d_snan",  1'b1, 1'b0, 11'h0, 53'h0, 4'b0011, {1'b1, 52'h1},
            64'h7FF8000000000001, 1'b1, 1'b0);

    // Standalone clear
    inv_clr = 1'b1;
    @(negedge clk);
    inv_clr = 1'b0;
    exp_sticky = 1'b0;
    chk("clr_sticky", 64'(inv_sticky), 64'd0);

    // Clear in the same cycle as a new invalid result: set wins
    run_vec("snan_clr", 1'b1, 1'b0, 11'h0, 53'h0, 4'b0010, 53'h0,
            64'h7FF8000000000000, 1'b1, 1'b1);

    // Streaming with a downstream stall; restart count from reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    sent = 0; got = 0; cyc = 0; prev_stall = 1'b0; prev_fp = '0;
    while (got < 8 && cyc < 60) begin
      out_ready = !(cyc >= 5 && cyc <= 7);
      in_valid  = (sent < 8);
      db = 1'b1; s = 1'b0; e = 11'h3FF; fl = 4'b0000; nan = '0;
      f = {1'b1, 52'(sent)};
      #1;
      if (prev_stall) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_fp", fp, prev_fp);
      end
      if (!out_ready) chk("stall_in_ready", 64'(in_ready), 64'd0);
      if (out_valid && out_ready) begin
        chk("stream_fp", fp, 64'h3FF0000000000000 | 64'(got));
        got++;
      end
      if (in_valid && in_ready) sent++;
      prev_stall = out_valid && !out_ready;
      prev_fp    = fp;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    chk("stream_count", 64'(got), 64'd8);
    chk("stream_cnt", 64'(pack_cnt), 64'd8);

    // Reset with the pipe full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    f = 53'h1 << 52;
    repeat (3) @(negedge clk);
    chk("full_valid", 64'(out_valid), 64'd1);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rfull_valid", 64'(out_valid), 64'd0);
    chk("rfull_cnt", 64'(pack_cnt), 64'd0);
    chk("rfull_in_ready", 64'(in_ready), 64'd1);
    chk("rfull_fp", fp, 64'h0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rfull_no_ghost", 64'(out_valid), 64'd0);
    chk("rfull_cnt2", 64'(pack_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
